// File: rtl/sp_ram_arbiter_if.sv
// Request/response and single-port RAM signal bundle for sp_ram_arbiter.
// slave = arbiter side, master = requesters plus RAM environment.
interface sp_ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);

  // Requester A
  logic                  a_valid;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ready;
  logic                  a_rsp_valid;

  // Requester B
  logic                  b_valid;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ready;
  logic                  b_rsp_valid;

  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  // Single-port RAM
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output a_ready, a_rsp_valid, b_ready, b_rsp_valid,
    output rsp_rdata, busy,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  a_ready, a_rsp_valid, b_ready, b_rsp_valid,
    input  rsp_rdata, busy,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );

endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-requester arbiter in front of a single-port registered-output RAM.
// Define SP_RAM_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module sp_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  sp_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic gnt_a_c, gnt_b_c;

  // Latched request attributes for the operation in flight
  logic we_q, we_n;
  logic gnt_b_q, gnt_b_n;

  logic                  ram_cs_q, ram_cs_n;
  logic                  ram_we_q, ram_we_n;
  logic                  ram_oe_q, ram_oe_n;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_n;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;
  logic                  a_rsp_q, a_rsp_n;
  logic                  b_rsp_q, b_rsp_n;
  logic                  busy_q, busy_n;

`ifndef SP_RAM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: 1 means B was granted last, so A wins the next tie
  logic last_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else if (gnt_a_c || gnt_b_c) begin
      last_b_q <= gnt_b_c;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state, grant and next values of the registered outputs
  always_comb begin
    state_n     = state_q;
    gnt_a_c     = 1'b0;
    gnt_b_c     = 1'b0;
    we_n        = we_q;
    gnt_b_n     = gnt_b_q;
    ram_addr_n  = ram_addr_q;
    ram_wdata_n = ram_wdata_q;
    rsp_rdata_n = rsp_rdata_q;
    a_rsp_n     = 1'b0;
    b_rsp_n     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst && (bus.a_valid || bus.b_valid)) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
          gnt_a_c = bus.a_valid;
`else
          gnt_a_c = bus.a_valid && (!bus.b_valid || last_b_q);
`endif
          gnt_b_c     = !gnt_a_c;
          state_n     = ACC;
          gnt_b_n     = gnt_b_c;
          we_n        = gnt_a_c ? bus.a_we    : bus.b_we;
          ram_addr_n  = gnt_a_c ? bus.a_addr  : bus.b_addr;
          ram_wdata_n = gnt_a_c ? bus.a_wdata : bus.b_wdata;
        end
      end
      ACC: begin
        state_n = we_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        // RAM data issued in ACC is valid now; present it next cycle
        state_n     = IDLE;
        rsp_rdata_n = bus.ram_rdata;
        a_rsp_n     = !gnt_b_q;
        b_rsp_n     = gnt_b_q;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    ram_cs_n = (state_n == ACC) || (state_n == RD_WAIT);
    ram_we_n = (state_n == ACC) && we_n;
    ram_oe_n = ((state_n == ACC) && !we_n) || (state_n == RD_WAIT);
    busy_n   = (state_n != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      gnt_b_q     <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_rdata_q <= '0;
      a_rsp_q     <= 1'b0;
      b_rsp_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      we_q        <= we_n;
      gnt_b_q     <= gnt_b_n;
      ram_cs_q    <= ram_cs_n;
      ram_we_q    <= ram_we_n;
      ram_oe_q    <= ram_oe_n;
      ram_addr_q  <= ram_addr_n;
      ram_wdata_q <= ram_wdata_n;
      rsp_rdata_q <= rsp_rdata_n;
      a_rsp_q     <= a_rsp_n;
      b_rsp_q     <= b_rsp_n;
      busy_q      <= busy_n;
    end
  end

  // Ready is an acceptance strobe in the same cycle as valid
  assign bus.a_ready     = gnt_a_c;
  assign bus.b_ready     = gnt_b_c;
  assign bus.a_rsp_valid = a_rsp_q;
  assign bus.b_rsp_valid = b_rsp_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.busy        = busy_q;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_oe      = ram_oe_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: transaction-level schedule model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sp_ram_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Environment RAM: registered read data, valid the cycle after a read is issued
  logic [DW-1:0] ram_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_oe) bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  // Model: one outstanding transaction described by its accept cycle
  int            cyc    = 0;
  bit            chk_en = 1'b0;
  bit            act    = 1'b0;
  int            t0     = 0;
  int            t_free = 0;
  bit            t_we   = 1'b0;
  bit            t_b    = 1'b0;
  logic [DW-1:0] t_data = '0;
  bit            last_b = 1'b1;
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [DW-1:0] e_rdata = '0;
  logic [DW-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin : model
    bit can, ea, eb, e1, e2, ers;
    can = !rst && (!act || cyc >= t_free);
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    ea = can && bus.a_valid;
`else
    ea = can && bus.a_valid && (!bus.b_valid || last_b);
`endif
    eb  = can && bus.b_valid && !ea;
    e1  = act && (cyc == t0 + 1);
    e2  = act && !t_we && (cyc == t0 + 2);
    ers = act && !t_we && (cyc == t0 + 3);
    if (ers) e_rdata = t_data;

    if (chk_en) begin
      chk("m_a_ready",     32'(bus.a_ready),     32'(ea));
      chk("m_b_ready",     32'(bus.b_ready),     32'(eb));
      chk("m_a_rsp_valid", 32'(bus.a_rsp_valid), 32'(ers && !t_b));
      chk("m_b_rsp_valid", 32'(bus.b_rsp_valid), 32'(ers && t_b));
      chk("m_ram_cs",      32'(bus.ram_cs),      32'(e1 || e2));
      chk("m_ram_we",      32'(bus.ram_we),      32'(e1 && t_we));
      chk("m_ram_oe",      32'(bus.ram_oe),      32'((e1 && !t_we) || e2));
      chk("m_busy",        32'(bus.busy),        32'(e1 || e2));
      chk("m_ram_addr",    32'(bus.ram_addr),    32'(e_addr));
      chk("m_ram_wdata",   32'(bus.ram_wdata),   32'(e_wdata));
      chk("m_rsp_rdata",   32'(bus.rsp_rdata),   32'(e_rdata));
    end

    if (rst) begin
      act     = 1'b0;
      last_b  = 1'b1;
      e_addr  = '0;
      e_wdata = '0;
      e_rdata = '0;
      chk_en  = 1'b1;
    end else if (ea || eb) begin
      act     = 1'b1;
      t0      = cyc;
      t_b     = eb;
      t_we    = ea ? bus.a_we : bus.b_we;
      e_addr  = ea ? bus.a_addr : bus.b_addr;
      e_wdata = ea ? bus.a_wdata : bus.b_wdata;
      t_free  = cyc + (t_we ? 2 : 3);
      if (t_we) ref_mem[e_addr] = e_wdata;
      else      t_data = ref_mem[e_addr];
      last_b  = eb;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [AW-1:0] addr_set [4];
    bit            a_pend, b_pend, ga, gb;
    addr_set[0] = 8'h10; addr_set[1] = 8'h20; addr_set[2] = 8'h30; addr_set[3] = 8'hFF;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.ram_rdata = '0;
    bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Reset state
    tick(); tick();
    look();
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_ram_cs",    32'(bus.ram_cs),    32'h0);
    chk("rst_ram_addr",  32'(bus.ram_addr),  32'h0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);

    // A writes 0x5A to 0x10
    tick(); rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h10; bus.a_wdata = 8'h5A;
    look(); chk("wr_a_ready", 32'(bus.a_ready), 32'h1);
    tick(); bus.a_valid = 1'b0;
    look();
    chk("wr_cs",    32'(bus.ram_cs),    32'h1);
    chk("wr_we",    32'(bus.ram_we),    32'h1);
    chk("wr_addr",  32'(bus.ram_addr),  32'h10);
    chk("wr_wdata", 32'(bus.ram_wdata), 32'h5A);
    tick(); look(); chk("wr_busy_low", 32'(bus.busy), 32'h0);

    // A reads 0x10 back
    tick(); bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h10; bus.a_wdata = '0;
    look(); chk("rd_a_ready", 32'(bus.a_ready), 32'h1);
    tick(); bus.a_valid = 1'b0;
    look(); chk("rd_t1_cs", 32'(bus.ram_cs), 32'h1); chk("rd_t1_oe", 32'(bus.ram_oe), 32'h1);
    tick(); look(); chk("rd_t2_cs", 32'(bus.ram_cs), 32'h1); chk("rd_t2_oe", 32'(bus.ram_oe), 32'h1);
    tick(); look();
    chk("rd_t3_rsp",   32'(bus.a_rsp_valid), 32'h1);
    chk("rd_t3_rdata", 32'(bus.rsp_rdata),   32'h5A);

    // Both requesters hold valid: grant pattern after a fresh reset
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h30; bus.a_wdata = 8'h11;
    bus.b_valid = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h31; bus.b_wdata = 8'h22;
    for (int i = 0; i < 8; i++) begin
      look();
      ga = (i % 2 == 0);
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
      ga = ga && (i % 4 == 0);
`endif
      gb = (i % 2 == 0) && !ga;
      chk("tie_a_ready", 32'(bus.a_ready), 32'(ga));
      chk("tie_b_ready", 32'(bus.b_ready), 32'(gb));
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    // B read of 0x20 abandoned by reset during RD_WAIT
    bus.b_valid = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h20; bus.b_wdata = '0;
    look(); chk("abort_b_ready", 32'(bus.b_ready), 32'h1);
    tick(); bus.b_valid = 1'b0;
    look();
    tick(); rst = 1'b1;
    look(); chk("abort_rdwait_cs", 32'(bus.ram_cs), 32'h1);
    tick(); rst = 1'b0;
    look();
    chk("abort_b_rsp", 32'(bus.b_rsp_valid), 32'h0);
    chk("abort_cs",    32'(bus.ram_cs),      32'h0);
    chk("abort_oe",    32'(bus.ram_oe),      32'h0);
    chk("abort_busy",  32'(bus.busy),        32'h0);
    chk("abort_addr",  32'(bus.ram_addr),    32'h0);
    tick(); look(); chk("abort_b_rsp_late", 32'(bus.b_rsp_valid), 32'h0);

    // Back-to-back B writes across the address wrap
    tick(); bus.b_valid = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'hFF; bus.b_wdata = 8'hA1;
    look(); chk("b2b_ready0", 32'(bus.b_ready), 32'h1);
    tick(); bus.b_addr = 8'h00; bus.b_wdata = 8'hA2;
    look();
    chk("b2b_gap_ready", 32'(bus.b_ready),  32'h0);
    chk("b2b_addr_ff",   32'(bus.ram_addr), 32'hFF);
    tick(); look(); chk("b2b_ready1", 32'(bus.b_ready), 32'h1);
    tick(); bus.b_valid = 1'b0;
    look(); chk("b2b_addr_00", 32'(bus.ram_addr), 32'h00); chk("b2b_wdata", 32'(bus.ram_wdata), 32'hA2);
    tick(); look(); chk("b2b_no_extra_cs", 32'(bus.ram_cs), 32'h0);

    // A read while B waits: B accepted in the cycle A's response pulses
    tick();
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'hFF; bus.a_wdata = '0;
    bus.b_valid = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h00; bus.b_wdata = '0;
    look(); chk("ov_a_ready", 32'(bus.a_ready), 32'h1);
    tick(); bus.a_valid = 1'b0;
    look(); tick(); look();
    tick(); look();
    chk("ov_a_rsp",   32'(bus.a_rsp_valid), 32'h1);
    chk("ov_a_rdata", 32'(bus.rsp_rdata),   32'hA1);
    chk("ov_b_ready", 32'(bus.b_ready),     32'h1);
    tick(); bus.b_valid = 1'b0;
    look(); tick(); look();
    tick(); look();
    chk("ov_b_rsp",   32'(bus.b_rsp_valid), 32'h1);
    chk("ov_b_rdata", 32'(bus.rsp_rdata),   32'hA2);

    // Mixed traffic, checked by the model each cycle
    a_pend = 1'b0; b_pend = 1'b0;
    for (int i = 0; i < 60; i++) begin
      look();
      if (bus.a_ready) a_pend = 1'b0;
      if (bus.b_ready) b_pend = 1'b0;
      tick();
      if (!a_pend) begin
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_we    = 1'($urandom_range(0, 1));
        bus.a_addr  = addr_set[$urandom_range(0, 3)];
        bus.a_wdata = DW'($urandom_range(0, 255));
        a_pend      = bus.a_valid;
      end
      if (!b_pend) begin
        bus.b_valid = 1'($urandom_range(0, 1));
        bus.b_we    = 1'($urandom_range(0, 1));
        bus.b_addr  = addr_set[$urandom_range(0, 3)];
        bus.b_wdata = DW'($urandom_range(0, 255));
        b_pend      = bus.b_valid;
      end
    end
    // Let any accepted-but-pending handshake finish, then drain
    for (int i = 0; i < 8 && (a_pend || b_pend); i++) begin
      look();
      if (bus.a_ready) a_pend = 1'b0;
      if (bus.b_ready) b_pend = 1'b0;
      tick();
      if (!a_pend) bus.a_valid = 1'b0;
      if (!b_pend) bus.b_valid = 1'b0;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (5) tick();
    look();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
